vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Single-port frame-buffer RAM arbiter. Display scan-out reads
//            have priority, writer pixels are buffered in a small FIFO and
//            drained in idle slots. A starvation counter forces one write
//            when the FIFO has been full for STARVE_LIMIT display grants.
// Options  : VRAM_ARBITER_STATS_EN adds the stall_cnt output, a saturating
//            count of cycles where the writer was blocked by a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // display scan-out read port
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic                        disp_gnt,
  output logic                        disp_valid,
  output logic [DATA_W-1:0]           disp_data,
  // writer push port
  input  logic                        wr_req,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  // RAM port
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  // status
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef VRAM_ARBITER_STATS_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_ST_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // current-cycle arbitration decision and the one from the previous cycle
  state_t              w_state;
  state_t              r_state;

  // write FIFO storage and bookkeeping
  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_ST_W-1:0]   r_starve;

  // read return pipeline
  logic                r_disp_valid;
  logic [DATA_W-1:0]   r_disp_data;

  logic                w_full;
  logic                w_empty;
  logic                w_forced;
  logic                w_push;
  logic                w_pop;

  assign w_full   = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  // the writer has waited long enough behind the display: steal one slot
  assign w_forced = w_full && (r_starve == c_ST_W'(STARVE_LIMIT));
  // a full FIFO refuses the push even if the head pops this same cycle
  assign w_push   = wr_req && !w_full;
  assign w_pop    = (w_state == ST_WRITE);

  assign wr_ready   = !w_full;
  assign fifo_count = r_count;
  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_data;

  // Arbitration and RAM/grant outputs; everything is held quiet during reset.
  always_comb begin
    w_state   = ST_IDLE;
    disp_gnt  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (disp_req && !w_forced) begin
        w_state = ST_READ;
      end else if (!w_empty) begin
        w_state = ST_WRITE;
      end
    end
    case (w_state)
      ST_READ: begin
        disp_gnt = 1'b1;
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_fifo_addr[r_rptr];
        mem_wdata = r_fifo_data[r_rptr];
      end
      default: begin
      end
    endcase
  end

  // Previous-cycle state register; READ here means mem_rdata is live now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // FIFO payload storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter: counts display grants taken while the FIFO is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!w_full || w_forced) begin
      r_starve <= '0;
    end else if ((w_state == ST_READ) && (r_starve != c_ST_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + c_ST_W'(1);
    end
  end

  // Read return: capture RAM data one cycle after the grant, flag it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else begin
      r_disp_valid <= (r_state == ST_READ);
      if (r_state == ST_READ) begin
        r_disp_data <= mem_rdata;
      end
    end
  end

`ifdef VRAM_ARBITER_STATS_EN
  logic [15:0] r_stall;

  assign stall_cnt = r_stall;

  // Writer stall statistics, saturating so a long stall never wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (wr_req && w_full && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Directed self-checking bench for vram_arbiter with a behavioural
//            one-cycle-latency RAM and a log of every RAM write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        disp_gnt;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [2:0]  fifo_count;
`ifdef VRAM_ARBITER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  ram [logic [18:0]];
  logic [26:0] wlog [$];

  vram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_gnt   (disp_gnt),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef VRAM_ARBITER_STATS_EN
    .stall_cnt  (stall_cnt),
`endif
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous RAM with one-cycle read latency; writes are logged in order
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] = mem_wdata;
        wlog.push_back({mem_addr, mem_wdata});
      end else begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 8'h00;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; disp_req = 1'b1; disp_addr = 19'h00005;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({wr_ready, fifo_count, mem_en, mem_we, disp_gnt, disp_valid} !== {1'b1, 3'd0, 4'b0000}) begin
      $display("FAIL reset_ctl: got rdy=%b cnt=%0d en=%b we=%b gnt=%b vld=%b want 1 0 0 0 0 0",
               wr_ready, fifo_count, mem_en, mem_we, disp_gnt, disp_valid);
      n_err++;
    end
    n_vec++;
    if ({disp_data, mem_addr, mem_wdata} !== 35'd0) begin
      $display("FAIL reset_bus: got data=%h addr=%h wdata=%h want 0 0 0", disp_data, mem_addr, mem_wdata);
      n_err++;
    end
`ifdef VRAM_ARBITER_STATS_EN
    n_vec++;
    if (stall_cnt !== 16'd0) begin
      $display("FAIL reset_stall: got %0d want 0", stall_cnt);
      n_err++;
    end
`endif
    @(negedge clk);
    disp_req = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 19'h00123;
    #1;
    n_vec++;
    if ({disp_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 19'h00123}) begin
      $display("FAIL rd_grant: got gnt=%b en=%b we=%b addr=%h want 1 1 0 00123",
               disp_gnt, mem_en, mem_we, mem_addr);
      n_err++;
    end
    @(negedge clk);
    disp_req = 1'b0;
    #1;
    n_vec++;
    if ({disp_valid, mem_en} !== 2'b00) begin
      $display("FAIL rd_lat1: got vld=%b en=%b want 0 0", disp_valid, mem_en);
      n_err++;
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({disp_valid, disp_data} !== {1'b1, 8'hE0}) begin
      $display("FAIL rd_data: got vld=%b data=%h want 1 e0", disp_valid, disp_data);
      n_err++;
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (disp_valid !== 1'b0) begin
      $display("FAIL rd_pulse: got vld=%b want 0", disp_valid);
      n_err++;
    end
  endtask

  task automatic test_writes();
    logic [18:0] ea [5];
    logic [7:0]  ed [5];
    logic        ewe [5];
    logic [2:0]  ec [5];
    logic        wq [5];
    logic [18:0] wa [5];
    logic [7:0]  wd [5];
    ea  = '{19'h0, 19'h1, 19'h2, 19'h3, 19'h0};
    ed  = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    ewe = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ec  = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
    wq  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    wa  = '{19'h1, 19'h2, 19'h3, 19'h0, 19'h0};
    wd  = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
    wlog.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      disp_req = 1'b0;
      wr_req = wq[c]; wr_addr = wa[c]; wr_data = wd[c];
      #1;
      n_vec++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, fifo_count, disp_gnt} !==
          {ewe[c], ewe[c], ea[c], ed[c], ec[c], 1'b0}) begin
        $display("FAIL wr_cycle%0d: got en=%b we=%b addr=%h wd=%h cnt=%0d want %b %b %h %h %0d",
                 c, mem_en, mem_we, mem_addr, mem_wdata, fifo_count,
                 ewe[c], ewe[c], ea[c], ed[c], ec[c]);
        n_err++;
      end
    end
    n_vec++;
    if (wlog.size() != 3 || wlog[0] !== {19'h1, 8'hAA} || wlog[1] !== {19'h2, 8'hBB} ||
        wlog[2] !== {19'h3, 8'hCC}) begin
      $display("FAIL wr_log: got %0d writes, want 3 in order 1/aa 2/bb 3/cc", wlog.size());
      n_err++;
    end
  endtask

  task automatic test_push_pop_wrap();
    logic        dq [7];
    logic        wq [7];
    logic [18:0] wa [7];
    logic [7:0]  wd [7];
    logic        ewe [7];
    logic [18:0] ea [7];
    logic [7:0]  ed [7];
    logic [2:0]  ec [7];
    dq  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    wa  = '{19'h10, 19'h20, 19'h30, 19'h40, 19'h0, 19'h0, 19'h0};
    wd  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
    ewe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ea  = '{19'h77, 19'h77, 19'h10, 19'h20, 19'h30, 19'h40, 19'h0};
    ed  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    ec  = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0};
    wlog.delete();
    disp_addr = 19'h77;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      disp_req = dq[c];
      wr_req = wq[c]; wr_addr = wa[c]; wr_data = wd[c];
      #1;
      n_vec++;
      if ({disp_gnt, mem_en, mem_we, mem_addr, mem_wdata, fifo_count} !==
          {dq[c], dq[c] | ewe[c], ewe[c], ea[c], ed[c], ec[c]}) begin
        $display("FAIL wrap_cycle%0d: got gnt=%b en=%b we=%b addr=%h wd=%h cnt=%0d want %b %b %b %h %h %0d",
                 c, disp_gnt, mem_en, mem_we, mem_addr, mem_wdata, fifo_count,
                 dq[c], dq[c] | ewe[c], ewe[c], ea[c], ed[c], ec[c]);
        n_err++;
      end
    end
    n_vec++;
    if (wlog.size() != 4 || wlog[0] !== {19'h10, 8'h11} || wlog[1] !== {19'h20, 8'h22} ||
        wlog[2] !== {19'h30, 8'h33} || wlog[3] !== {19'h40, 8'h44}) begin
      $display("FAIL wrap_log: got %0d writes, want 4 in push order", wlog.size());
      n_err++;
    end
  endtask

  task automatic test_overflow();
    int acc = 0;
    logic ok;
    wlog.delete();
    disp_req = 1'b1; disp_addr = 19'h200;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      if (c == 22) disp_req = 1'b0;
      wr_req  = (acc < 6);
      wr_addr = 19'h100 + 19'(acc);
      wr_data = 8'h50 + 8'(acc);
      #1;
      if (c == 3) begin
        n_vec++;
        if ({disp_gnt, wr_ready, fifo_count} !== {2'b11, 3'd3}) begin
          $display("FAIL ovf_pre: got gnt=%b rdy=%b cnt=%0d want 1 1 3", disp_gnt, wr_ready, fifo_count);
          n_err++;
        end
      end
      if (c >= 4 && c <= 19) begin
        n_vec++;
        if ({disp_gnt, wr_ready, mem_we, fifo_count} !== {3'b100, 3'd4}) begin
          $display("FAIL ovf_starve%0d: got gnt=%b rdy=%b we=%b cnt=%0d want 1 0 0 4",
                   c, disp_gnt, wr_ready, mem_we, fifo_count);
          n_err++;
        end
      end
      if (c == 20) begin
        n_vec++;
        if ({disp_gnt, mem_en, mem_we, mem_addr, mem_wdata, wr_ready} !== {3'b011, 19'h100, 8'h50, 1'b0}) begin
          $display("FAIL ovf_forced: got gnt=%b en=%b we=%b addr=%h wd=%h rdy=%b want 0 1 1 00100 50 0",
                   disp_gnt, mem_en, mem_we, mem_addr, mem_wdata, wr_ready);
          n_err++;
        end
      end
      if (c == 21) begin
        n_vec++;
        if ({disp_gnt, wr_ready, fifo_count} !== {2'b11, 3'd3}) begin
          $display("FAIL ovf_after: got gnt=%b rdy=%b cnt=%0d want 1 1 3", disp_gnt, wr_ready, fifo_count);
          n_err++;
        end
      end
      if (c == 22) begin
        n_vec++;
        if ({mem_we, mem_addr, wr_ready, fifo_count} !== {1'b1, 19'h101, 1'b0, 3'd4}) begin
          $display("FAIL ovf_fullpop: got we=%b addr=%h rdy=%b cnt=%0d want 1 00101 0 4",
                   mem_we, mem_addr, wr_ready, fifo_count);
          n_err++;
        end
      end
      if (c == 27) begin
        n_vec++;
        if ({mem_en, fifo_count} !== {1'b0, 3'd0}) begin
          $display("FAIL ovf_drain: got en=%b cnt=%0d want 0 0", mem_en, fifo_count);
          n_err++;
        end
      end
      if (wr_req && wr_ready) acc++;
    end
    wr_req = 1'b0;
    ok = (wlog.size() == 6);
    for (int i = 0; i < 6 && ok; i++) begin
      if (wlog[i] !== {19'h100 + 19'(i), 8'h50 + 8'(i)}) ok = 1'b0;
    end
    n_vec++;
    if (!ok) begin
      $display("FAIL ovf_log: got %0d writes or wrong order, want 6 in push order", wlog.size());
      n_err++;
    end
`ifdef VRAM_ARBITER_STATS_EN
    n_vec++;
    if (stall_cnt !== 16'd18) begin
      $display("FAIL ovf_stall: got %0d want 18", stall_cnt);
      n_err++;
    end
`endif
  endtask

  task automatic test_reset_midop();
    wlog.delete();
    disp_addr = 19'h300;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      disp_req = 1'b1; wr_req = 1'b1;
      wr_addr = 19'h400 + 19'(c); wr_data = 8'h90 + 8'(c);
      #1;
      n_vec++;
      if ({disp_gnt, fifo_count} !== {1'b1, 3'(c)}) begin
        $display("FAIL mid_pre%0d: got gnt=%b cnt=%0d want 1 %0d", c, disp_gnt, fifo_count, c);
        n_err++;
      end
    end
    @(negedge clk);
    rst_n = 1'b0; wr_req = 1'b0;
    #1;
    n_vec++;
    if ({fifo_count, disp_gnt, mem_en, wr_ready, disp_valid} !== {3'd0, 4'b0010}) begin
      $display("FAIL mid_rst: got cnt=%0d gnt=%b en=%b rdy=%b vld=%b want 0 0 0 1 0",
               fifo_count, disp_gnt, mem_en, wr_ready, disp_valid);
      n_err++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; disp_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if ({disp_valid, mem_en, fifo_count} !== {2'b00, 3'd0}) begin
        $display("FAIL mid_post%0d: got vld=%b en=%b cnt=%0d want 0 0 0", c, disp_valid, mem_en, fifo_count);
        n_err++;
      end
      @(negedge clk);
    end
    n_vec++;
    if (wlog.size() != 0) begin
      $display("FAIL mid_discard: got %0d RAM writes want 0", wlog.size());
      n_err++;
    end
  endtask

  initial begin
    mem_rdata = 8'h00;
    ram[19'h00123] = 8'hE0;
    test_reset();
    test_single_read();
    test_writes();
    test_push_pop_wrap();
    test_overflow();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
